simple_master: RTL and testbench

SIMPLE_MASTER -- requirements
Module: simple_master

---
 rtl/simple_master.sv | 204 ++++++++++++++++++++
 tb/tb_simple_master.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_master.sv
// simple_master: command/response front end for a simple register bus.
//
// Commands (write or read) are queued in a small FIFO. The FSM takes one
// command at a time, drives a single-cycle re or we strobe on the bus,
// waits RD_LAT cycles for read data when needed, and then presents a
// response. A separate block tracks rising edges of an interrupt line.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. cmd_ready is !full, so a push is refused
// when the FIFO is full even if a pop happens in the same cycle. The
// response holds rsp_valid and its fields stable until rsp_ready is high.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_we/cmd_addr/cmd_wd   command type (1 = write), address, write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_we/rsp_addr/rsp_rd   echoed type and address, read data (0 on writes)
//   addr/re/we/wd/rd         register bus
//   irq/irq_clr              interrupt input and pending-flag clear
//   irq_pend/irq_cnt         sticky pending flag, saturating edge count
//   o_dbg_state              current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
module simple_master #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_we,
  output logic [4:0]  rsp_addr,
  output logic [31:0] rsp_rd,
  output logic [4:0]  addr,
  output logic        re,
  output logic        we,
  output logic [31:0] wd,
  input  logic [31:0] rd,
  input  logic        irq,
  output logic        irq_pend,
  input  logic        irq_clr,
  output logic [7:0]  irq_cnt,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 38;  // {we, addr[4:0], wd[31:0]}

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [2:0]  LAT     = 3'(RD_LAT);

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [1:0]    r_state;
  logic [2:0]    r_lat_cnt;
  logic          r_is_wr;
  logic [4:0]    r_addr;
  logic [31:0]   r_wd;
  logic          r_re;
  logic          r_we;
  logic          r_rsp_valid;
  logic          r_rsp_we;
  logic [4:0]    r_rsp_addr;
  logic [31:0]   r_rsp_rd;
  logic          r_irq_d;
  logic          r_irq_pend;
  logic [7:0]    r_irq_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;
  logic          w_irq_edge;

  // Pointers carry one extra wrap bit: equal means empty, equal except the
  // wrap bit means full.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Held low during reset so nothing is accepted while the block clears.
  assign cmd_ready = !rst && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];

  assign w_irq_edge = irq && !r_irq_d;

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {cmd_we, cmd_addr, cmd_wd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_state     <= S_IDLE;
      r_lat_cnt   <= '0;
      r_is_wr     <= 1'b0;
      r_addr      <= '0;
      r_wd        <= '0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_rd    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;

      // Strobes are only ever set on the IDLE->ISSUE transition, so they
      // last exactly the one ISSUE cycle.
      r_re <= 1'b0;
      r_we <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_is_wr <= w_head[37];
            r_addr  <= w_head[36:32];
            r_wd    <= w_head[31:0];
            r_we    <= w_head[37];
            r_re    <= !w_head[37];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_is_wr) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b1;
            r_rsp_addr  <= r_addr;
            r_rsp_rd    <= '0;
            r_state     <= S_RESP;
          end else begin
            // The re cycle itself is count 0; the first WAIT cycle is 1.
            r_lat_cnt <= 3'd1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat_cnt == LAT) begin
            r_rsp_valid <= 1'b1;
            r_rsp_we    <= 1'b0;
            r_rsp_addr  <= r_addr;
            r_rsp_rd    <= rd;
            r_state     <= S_RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_d    <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irq_cnt  <= '0;
    end else begin
      r_irq_d <= irq;
      // A new edge wins over a simultaneous clear.
      if (w_irq_edge)   r_irq_pend <= 1'b1;
      else if (irq_clr) r_irq_pend <= 1'b0;
      if (w_irq_edge && (r_irq_cnt != 8'hFF)) r_irq_cnt <= r_irq_cnt + 8'd1;
    end
  end

  assign addr        = r_addr;
  assign wd          = r_wd;
  assign re          = r_re;
  assign we          = r_we;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_we      = r_rsp_we;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_rd      = r_rsp_rd;
  assign irq_pend    = r_irq_pend;
  assign irq_cnt     = r_irq_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_simple_master.sv
// Testbench for simple_master (RD_LAT=2, FIFO_DEPTH=4).
// Every command accepted by the bench pushes its expected strobe and its
// expected response into queues; a per-cycle monitor pops and compares
// them when the DUT strobes the bus or completes a response handshake.
module tb_simple_master;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_wd = '0;
  logic        rsp_ready = 1'b0;
  logic [31:0] rd = '0;
  logic        irq = 1'b0;
  logic        irq_clr = 1'b0;

  wire         cmd_ready;
  wire         rsp_valid;
  wire         rsp_we;
  wire [4:0]   rsp_addr;
  wire [31:0]  rsp_rd;
  wire [4:0]   addr;
  wire         re;
  wire         we;
  wire [31:0]  wd;
  wire         irq_pend;
  wire [7:0]   irq_cnt;
  wire [1:0]   dbg_state;

  simple_master #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wd(cmd_wd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_addr(rsp_addr), .rsp_rd(rsp_rd),
    .addr(addr), .re(re), .we(we), .wd(wd), .rd(rd),
    .irq(irq), .irq_pend(irq_pend), .irq_clr(irq_clr), .irq_cnt(irq_cnt),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rd_due = -1;
  logic [31:0] rd_data = '0;
  logic [31:0] model_mem [32];
  logic [31:0] bus_mem [32];
  logic [37:0] exp_q[$];       // {we, addr, rsp_rd}
  logic [37:0] exp_strb_q[$];  // {we, addr, wd}
  bit          rand_rdy = 1'b0;
  bit          sampled_ready = 1'b0;
  bit          prev_strobe = 1'b0;

  // ---------------- monitor / bus model ----------------
  task automatic mon();
    logic [37:0] e;
    if (rst) begin
      prev_strobe = 1'b0;
      return;
    end
    if (re || we) begin
      checks++;
      if (re && we) begin
        failures++;
        $display("FAIL strobe_both re=%0b we=%0b required only one", re, we);
      end
      checks++;
      if (prev_strobe) begin
        failures++;
        $display("FAIL strobe_gap strobe in consecutive cycles, required an idle cycle between");
      end
      checks++;
      if (exp_strb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe re=%0b we=%0b addr=%h, required no strobe", re, we, addr);
      end else begin
        e = exp_strb_q.pop_front();
        if ({we, addr} !== e[37:32] || (we && wd !== e[31:0])) begin
          failures++;
          $display("FAIL strobe we=%0b addr=%h wd=%h, required we=%0b addr=%h wd=%h",
                   we, addr, wd, e[37], e[36:32], e[31:0]);
        end
      end
      if (re) begin
        rd_due  = cyc + RD_LAT;
        rd_data = bus_mem[addr];
      end
      if (we) bus_mem[addr] = wd;
    end
    prev_strobe = re || we;
    if (rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp we=%0b addr=%h rd=%h, required none", rsp_we, rsp_addr, rsp_rd);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_we, rsp_addr, rsp_rd} !== e) begin
          failures++;
          $display("FAIL rsp we=%0b addr=%h rd=%h, required we=%0b addr=%h rd=%h",
                   rsp_we, rsp_addr, rsp_rd, e[37], e[36:32], e[31:0]);
        end
      end
    end
  endtask

  // One clock cycle: monitor at the falling edge, then drive the next
  // cycle's bus data and optional random rsp_ready just after the rising edge.
  task automatic tick();
    @(negedge clk);
    mon();
    sampled_ready = cmd_ready;
    @(posedge clk);
    #1;
    cyc++;
    rd = (cyc == rd_due) ? rd_data : $urandom;
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- driver / model ----------------
  task automatic model_accept(input logic w, input logic [4:0] a, input logic [31:0] d);
    if (w) begin
      model_mem[a] = d;
      exp_q.push_back({1'b1, a, 32'h0});
    end else begin
      exp_q.push_back({1'b0, a, model_mem[a]});
    end
    exp_strb_q.push_back({w, a, d});
  endtask

  task automatic push_cmd(input logic w, input logic [4:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_addr  = a;
    cmd_wd    = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (sampled_ready && !rst) ok = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (ok) model_accept(w, a, d);
    else begin
      failures++;
      $display("FAIL push_timeout cmd_ready=%0b, required acceptance within 100 cycles", cmd_ready);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || exp_strb_q.size() != 0); i++) tick();
    checks++;
    if (exp_q.size() != 0 || exp_strb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending rsp=%0d strobes=%0d, required 0 0",
               exp_q.size(), exp_strb_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cmd_ready, rsp_valid, rsp_we, re, we, irq_pend, dbg_state} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl ready=%0b rv=%0b rwe=%0b re=%0b we=%0b pend=%0b st=%0d, required all 0",
               cmd_ready, rsp_valid, rsp_we, re, we, irq_pend, dbg_state);
    end
    checks++;
    if ({rsp_addr, rsp_rd, addr, wd, irq_cnt} !== 82'h0) begin
      failures++;
      $display("FAIL reset_data raddr=%h rrd=%h addr=%h wd=%h cnt=%0d, required all 0",
               rsp_addr, rsp_rd, addr, wd, irq_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset cmd_ready=%0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    push_cmd(1'b1, 5'h04, 32'hDEADBEEF);       // now in T+1
    checks++;
    if (we !== 1'b0 || re !== 1'b0) begin
      failures++;
      $display("FAIL wr_t1 we=%0b re=%0b, required 0 0", we, re);
    end
    tick();                                     // T+2
    checks++;
    if ({we, re, addr, wd} !== {1'b1, 1'b0, 5'h04, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL wr_t2 we=%0b re=%0b addr=%h wd=%h, required 1 0 04 deadbeef", we, re, addr, wd);
    end
    tick();                                     // T+3
    checks++;
    if ({we, rsp_valid, rsp_we, rsp_addr, rsp_rd} !== {1'b0, 1'b1, 1'b1, 5'h04, 32'h0}) begin
      failures++;
      $display("FAIL wr_t3 we=%0b rv=%0b rwe=%0b raddr=%h rrd=%h, required 0 1 1 04 0",
               we, rsp_valid, rsp_we, rsp_addr, rsp_rd);
    end
    drain();
  endtask

  task automatic test_read();
    rsp_ready = 1'b1;
    model_mem[8] = 32'h12345678;
    bus_mem[8]   = 32'h12345678;
    push_cmd(1'b0, 5'h08, $urandom);            // T+1
    checks++;
    if (re !== 1'b0) begin
      failures++;
      $display("FAIL rd_t1 re=%0b, required 0", re);
    end
    tick();                                     // T+2
    checks++;
    if ({re, we, addr} !== {1'b1, 1'b0, 5'h08}) begin
      failures++;
      $display("FAIL rd_t2 re=%0b we=%0b addr=%h, required 1 0 08", re, we, addr);
    end
    for (int k = 3; k <= 4; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || re !== 1'b0) begin
        failures++;
        $display("FAIL rd_early T+%0d rv=%0b re=%0b, required 0 0", k, rsp_valid, re);
      end
    end
    tick();                                     // T+5
    checks++;
    if ({rsp_valid, rsp_we, rsp_addr, rsp_rd} !== {1'b1, 1'b0, 5'h08, 32'h12345678}) begin
      failures++;
      $display("FAIL rd_t5 rv=%0b rwe=%0b raddr=%h rrd=%h, required 1 0 08 12345678",
               rsp_valid, rsp_we, rsp_addr, rsp_rd);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    int acc = 0;
    bit new_cmd = 1'b1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (new_cmd) begin
        cmd_we   = 1'($urandom_range(0, 1));
        cmd_addr = 5'($urandom_range(0, 31));
        cmd_wd   = $urandom;
      end
      cmd_valid = 1'b1;
      tick();
      new_cmd = sampled_ready;
      if (sampled_ready) begin
        model_accept(cmd_we, cmd_addr, cmd_wd);
        acc++;
      end
    end
    cmd_valid = 1'b0;
    // One command is in flight (stalled in RESP) and FIFO_DEPTH are queued.
    checks++;
    if (acc != FIFO_DEPTH + 1) begin
      failures++;
      $display("FAIL full_accepts accepted=%0d, required %0d", acc, FIFO_DEPTH + 1);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_ready cmd_ready=%0b, required 0", cmd_ready);
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({rsp_valid, rsp_we, rsp_addr, rsp_rd} !== {1'b1, exp_q[0]} || re || we || cmd_ready) begin
        failures++;
        $display("FAIL stall cyc%0d rv=%0b rwe=%0b raddr=%h rrd=%h re=%0b we=%0b rdy=%0b, required 1 %0b %h %h 0 0 0",
                 k, rsp_valid, rsp_we, rsp_addr, rsp_rd, re, we, cmd_ready,
                 exp_q[0][37], exp_q[0][36:32], exp_q[0][31:0]);
      end
      tick();
    end
    rsp_ready = 1'b1;
    drain();
  endtask

  task automatic test_wrap();
    rand_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      push_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    drain();
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL wrap_idle cmd_ready=%0b state=%0d, required 1 0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    rsp_ready = 1'b1;
    push_cmd(1'b0, 5'h0C, $urandom);            // T+1
    push_cmd(1'b1, 5'h03, $urandom);            // T+2 (read strobe cycle)
    push_cmd(1'b1, 5'h07, $urandom);            // T+3
    checks++;
    if (dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL mid_wait state=%0d, required 2", dbg_state);
    end
    rst = 1'b1;
    exp_q.delete();
    exp_strb_q.delete();
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_ready_rst cmd_ready=%0b, required 0", cmd_ready);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({re, we, rsp_valid, cmd_ready} !== 4'b0000) begin
        failures++;
        $display("FAIL mid_in_reset re=%0b we=%0b rv=%0b rdy=%0b, required 0 0 0 0",
                 re, we, rsp_valid, cmd_ready);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid || re || we) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_after_reset late_activity=%0d cmd_ready=%0b, required 0 1", seen, cmd_ready);
    end
    push_cmd(1'b1, 5'h11, $urandom);
    drain();
  endtask

  task automatic test_irq();
    int exp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      irq = 1'b1;
      tick();
      irq = 1'b0;
      exp_cnt++;
      checks++;
      if (irq_pend !== 1'b1 || irq_cnt !== 8'(exp_cnt)) begin
        failures++;
        $display("FAIL irq_pulse%0d pend=%0b cnt=%0d, required 1 %0d", i, irq_pend, irq_cnt, exp_cnt);
      end
      tick();
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checks++;
    if (irq_pend !== 1'b0 || irq_cnt !== 8'd3) begin
      failures++;
      $display("FAIL irq_clr pend=%0b cnt=%0d, required 0 3", irq_pend, irq_cnt);
    end
    irq = 1'b1;
    irq_clr = 1'b1;
    tick();
    irq = 1'b0;
    irq_clr = 1'b0;
    exp_cnt = 4;
    checks++;
    if (irq_pend !== 1'b1 || irq_cnt !== 8'd4) begin
      failures++;
      $display("FAIL irq_set_wins pend=%0b cnt=%0d, required 1 4", irq_pend, irq_cnt);
    end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checks++;
    if (irq_pend !== 1'b0 || irq_cnt !== 8'd4) begin
      failures++;
      $display("FAIL irq_clr2 pend=%0b cnt=%0d, required 0 4", irq_pend, irq_cnt);
    end
    irq = 1'b1;
    repeat (6) tick();
    exp_cnt = 5;
    checks++;
    if (irq_cnt !== 8'd5) begin
      failures++;
      $display("FAIL irq_held cnt=%0d, required 5", irq_cnt);
    end
    irq = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      irq = 1'b1;
      tick();
      irq = 1'b0;
      tick();
      if (exp_cnt < 255) exp_cnt++;
    end
    checks++;
    if (irq_cnt !== 8'(exp_cnt) || irq_pend !== 1'b1) begin
      failures++;
      $display("FAIL irq_saturate cnt=%0d pend=%0b, required %0d 1", irq_cnt, irq_pend, exp_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = $urandom;
      bus_mem[i]   = model_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
